a3000_flash_programmer: RTL

- SPI-slave command decoder plus flash bus sequencer; sits between the MCU SPI link (cpld_SCK/MOSI/SS/MISO) and the dual 16-bit flash pair.
- Lets the MCU load, write and read back ROM images while the Archimedes is held off the ROM bus.
- Downstream flash mux selects this block's flash_* outputs when prog_active=1, and the motherboard pass-through path when prog_active=0.

---
 rtl/a3000_prog_pkg.sv | 14 +
 rtl/a3000_spi_byte_slave.sv | 62 ++++++
 rtl/a3000_flash_programmer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/a3000_prog_pkg.sv
// a3000_prog_pkg: opcodes, sequencer states and status bit positions for the flash programmer
package a3000_prog_pkg;
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_CONTROL  = 8'h04;
    localparam logic [7:0] OP_CLR_ERR  = 8'h05;
    localparam int STAT_BUSY = 7;
    localparam int STAT_ERR  = 6;
    localparam int STAT_VERR = 5;
    localparam int STAT_ARC  = 1;
    localparam int STAT_PROG = 0;
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_VERIFY} state_e;
endpackage

// File: rtl/a3000_spi_byte_slave.sv
// a3000_spi_byte_slave: mode-0 SPI slave, synchronised to the system clock, byte-wide rx/tx
module a3000_spi_byte_slave (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sck_i,
    input  logic       mosi_i,
    input  logic       ss_i,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       miso_o
);
    logic [2:0] sck_q, ss_q, bit_q;
    logic [1:0] mosi_q;
    logic [7:0] rx_q, tx_q;
    logic       load_q, miso_q, valid_q;
    logic       active, rise, fall;
    assign active        = ~ss_q[1];
    assign rise          = active & sck_q[1] & ~sck_q[2];
    assign fall          = active & ~sck_q[1] & sck_q[2];
    assign frame_start_o = ~ss_q[1] & ss_q[2];
    assign frame_end_o   = ss_q[1] & ~ss_q[2];
    assign rx_byte_o     = rx_q;
    assign byte_valid_o  = valid_q;
    assign miso_o        = miso_q;
    // While a byte load is pending, MISO follows tx_byte_i live so late read data still makes bit 7
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sck_q   <= '0;
            ss_q    <= '1;
            mosi_q  <= '0;
            bit_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            load_q  <= 1'b0;
            miso_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            sck_q   <= {sck_q[1:0], sck_i};
            ss_q    <= {ss_q[1:0], ss_i};
            mosi_q  <= {mosi_q[0], mosi_i};
            valid_q <= rise && bit_q == 3'd7;
            miso_q  <= active ? (load_q ? tx_byte_i[7] : tx_q[7]) : 1'b1;
            if (frame_start_o) begin
                bit_q  <= '0;
                load_q <= 1'b1;
            end else if (rise) begin
                rx_q  <= {rx_q[6:0], mosi_q[1]};
                bit_q <= bit_q + 3'd1;
                if (load_q) begin
                    tx_q   <= tx_byte_i;
                    load_q <= 1'b0;
                end
            end else if (fall) begin
                if (bit_q == 3'd0) load_q <= 1'b1;
                else tx_q <= {tx_q[6:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/a3000_flash_programmer.sv
// a3000_flash_programmer: SPI command decoder and flash bus sequencer; A3000_FLASH_VERIFY_EN adds write read-back verify
module a3000_flash_programmer
    import a3000_prog_pkg::*;
#(
    parameter int ADDR_W   = 22,
    parameter int WE_PULSE = 4,
    parameter int OE_PULSE = 6
) (
    input  logic              cpld_clock_osc,
    input  logic              cpld_nRESET,
    input  logic              cpld_SCK,
    input  logic              cpld_MOSI,
    input  logic              cpld_SS,
    output logic              cpld_MISO,
    output logic [ADDR_W-1:0] flash_A,
    output logic [31:0]       flash_D_out,
    output logic              flash_D_oe,
    input  logic [31:0]       flash_D_in,
    output logic              flash_nCE,
    output logic              flash_nOE,
    output logic              flash_nWE,
    output logic              prog_active,
    output logic              arc_reset_req
);
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d, vfy_q, vfy_d;
    logic [31:0]       rdata_q, dout_q;
    logic [ADDR_W-1:0] addr_q, fa_q;
    logic [7:0]        op_q;
    logic [2:0]        idx_q;
    logic [23:0]       sh_q;
    logic              err_q, verr_q, pa_req_q, pa_q, arc_q, rd_ok_q;
    logic              busy, ok, start_wr, start_rd, last_pulse;
    logic [7:0]        rx_byte, tx_byte, status;
    logic              byte_valid, frame_start, frame_end;
    a3000_spi_byte_slave u_spi (
        .clk_i        (cpld_clock_osc),
        .rst_n_i      (cpld_nRESET),
        .sck_i        (cpld_SCK),
        .mosi_i       (cpld_MOSI),
        .ss_i         (cpld_SS),
        .tx_byte_i    (tx_byte),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_start_o(frame_start),
        .frame_end_o  (frame_end),
        .miso_o       (cpld_MISO)
    );
    assign busy       = state_q != ST_IDLE;
    assign ok         = pa_q && !busy;
    assign last_pulse = state_q == ST_PULSE && cnt_q == 4'd0;
    assign start_rd   = byte_valid && idx_q == 3'd0 && rx_byte == OP_READ && ok;
    assign start_wr   = byte_valid && idx_q == 3'd4 && op_q == OP_WRITE && ok;
    assign status     = {busy, err_q, verr_q, 3'b000, arc_q, pa_q};
    assign tx_byte    = (op_q == OP_READ && idx_q != 3'd0 && idx_q <= 3'd4)
                      ? 8'(rdata_q >> (6'd32 - {idx_q, 3'b000})) : status;
    assign flash_A       = fa_q;
    assign flash_D_out   = dout_q;
    assign flash_D_oe    = wr_q && busy;
    assign flash_nCE     = !busy;
    assign flash_nWE     = !(state_q == ST_PULSE && wr_q);
    assign flash_nOE     = !(state_q == ST_PULSE && !wr_q);
    assign prog_active   = pa_q;
    assign arc_reset_req = arc_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        vfy_d   = vfy_q;
        case (state_q)
            ST_IDLE: if (start_wr || start_rd) begin
                state_d = ST_SETUP;
                wr_d    = start_wr;
                vfy_d   = 1'b0;
            end
            ST_SETUP, ST_VERIFY: begin
                state_d = ST_PULSE;
                cnt_d   = wr_q ? 4'(WE_PULSE - 1) : 4'(OE_PULSE - 1);
            end
            ST_PULSE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd0 ? ST_HOLD : ST_PULSE;
            end
`ifdef A3000_FLASH_VERIFY_EN
            ST_HOLD: begin
                state_d = wr_q ? ST_VERIFY : ST_IDLE;
                vfy_d   = wr_q;
                wr_d    = 1'b0;
            end
`else
            ST_HOLD: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge cpld_clock_osc) begin
        if (!cpld_nRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            vfy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            vfy_q   <= vfy_d;
            rdata_q <= (last_pulse && !wr_q && !vfy_q) ? flash_D_in : rdata_q;
        end
    end
    // Command decoder: idx_q counts completed bytes in the current frame, saturating at 7
    always_ff @(posedge cpld_clock_osc) begin
        if (!cpld_nRESET) begin
            addr_q   <= '0;
            fa_q     <= '0;
            dout_q   <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            err_q    <= 1'b0;
            verr_q   <= 1'b0;
            pa_req_q <= 1'b0;
            pa_q     <= 1'b0;
            arc_q    <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            pa_q <= busy ? pa_q : pa_req_q;
            if (start_wr) begin
                fa_q   <= addr_q;
                dout_q <= {sh_q, rx_byte};
            end
            if (start_rd) fa_q <= addr_q;
`ifdef A3000_FLASH_VERIFY_EN
            if (last_pulse && vfy_q && flash_D_in != dout_q) verr_q <= 1'b1;
`endif
            if (frame_start || frame_end) begin
                idx_q <= '0;
            end else if (byte_valid) begin
                idx_q <= idx_q == 3'd7 ? idx_q : idx_q + 3'd1;
                sh_q  <= {sh_q[15:0], rx_byte};
                if (idx_q == 3'd0) begin
                    op_q    <= rx_byte;
                    rd_ok_q <= ok;
                    if (rx_byte == OP_CLR_ERR) begin
                        err_q  <= 1'b0;
                        verr_q <= 1'b0;
                    end else if ((rx_byte == OP_READ && !ok) || rx_byte == 8'h00 || rx_byte > OP_CLR_ERR) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    if (op_q == OP_SET_ADDR && idx_q == 3'd3) addr_q <= ADDR_W'({sh_q[15:0], rx_byte});
                    if (op_q == OP_WRITE && idx_q == 3'd4) begin
                        if (ok) addr_q <= addr_q + ADDR_W'(1);
                        else err_q <= 1'b1;
                    end
                    if (op_q == OP_READ && idx_q == 3'd4 && rd_ok_q) addr_q <= addr_q + ADDR_W'(1);
                    if (op_q == OP_CONTROL && idx_q == 3'd1) begin
                        pa_req_q <= rx_byte[0];
                        arc_q    <= rx_byte[1];
                    end
                end
            end
        end
    end
endmodule
